btn_input_decoder: RTL and testbench

- Input-side counterpart to the board output multiplexer: conditions the five push-buttons (btnC/U/D/R/L) into clean, synchronised, debounced levels and single-cycle press events.
- Encodes press events into a 3-bit key code with a valid strobe, plus hold-to-repeat, for consumption by game/quarantine subtasks.
- Sits between the raw board pins and any subtask that reads buttons.

---
 rtl/btn_pkg.sv | 38 +++
 rtl/btn_debounce.sv | 46 ++++
 rtl/btn_input_decoder.sv | 104 ++++++++++
 tb/tb_btn_input_decoder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button input path:
// button bit indices, key codes, repeat FSM states and the key event record.
package btn_pkg;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_R = 3;
  localparam int BTN_L = 4;

  localparam logic [2:0] KEY_NONE = 3'd0;
  localparam logic [2:0] KEY_C    = 3'd1;
  localparam logic [2:0] KEY_U    = 3'd2;
  localparam logic [2:0] KEY_D    = 3'd3;
  localparam logic [2:0] KEY_R    = 3'd4;
  localparam logic [2:0] KEY_L    = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] code;
    logic       rpt;
    logic       multi;
  } key_evt_t;

  // Lowest bit index wins, so C beats U beats D beats R beats L.
  function automatic logic [2:0] prio_code(input logic [4:0] p);
    prio_code = KEY_NONE;
    for (int i = 4; i >= 0; i--)
      if (p[i]) prio_code = 3'(i) + KEY_C;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser, hold-time debounce counter, stable level
// and a registered single-cycle pulse on each debounced rising edge.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          stable;
  logic          stable_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= '0;
      cnt      <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      press    <= 1'b0;
    end else begin
      sync     <= {sync[0], pin};
      stable_d <= stable;
      press    <= stable & ~stable_d;
      // Any return to the stable value restarts the hold window.
      if (sync[1] == stable)
        cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        cnt    <= '0;
        stable <= ~stable;
      end else
        cnt <= cnt + 1'b1;
    end
  end

  assign level = stable;

endmodule

// File: rtl/btn_input_decoder.sv
// Five board buttons -> debounced levels, press pulses, and an encoded key
// strobe with hold-to-repeat.
module btn_input_decoder
  import btn_pkg::*;
#(
  parameter int N_BTN        = 5,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int REPEAT_DLY   = 50000000,
  parameter int REPEAT_RATE  = 10000000
) (
  input  logic             CLOCK,
  input  logic             RESETN,
  input  logic             btnC,
  input  logic             btnU,
  input  logic             btnD,
  input  logic             btnR,
  input  logic             btnL,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [2:0]       key_code,
  output logic             key_valid,
  output logic             key_rpt,
  output logic             key_multi
);

  localparam int TMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX);

  logic [N_BTN-1:0] pins;
  assign pins[BTN_C] = btnC;
  assign pins[BTN_U] = btnU;
  assign pins[BTN_D] = btnD;
  assign pins[BTN_R] = btnR;
  assign pins[BTN_L] = btnL;

  for (genvar i = 0; i < N_BTN; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk  (CLOCK),
      .rst_n(RESETN),
      .pin  (pins[i]),
      .level(btn_level[i]),
      .press(btn_press[i])
    );
  end

  rpt_state_t       state, state_nx;
  logic [TW-1:0]    timer, timer_nx;
  logic [N_BTN-1:0] lat, lat_nx;
  key_evt_t         key, key_nx;

  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      state <= ST_IDLE;
      timer <= '0;
      lat   <= '0;
      key   <= '0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      lat   <= lat_nx;
      key   <= key_nx;
    end
  end

  // A fresh press always wins over a repeat falling due in the same cycle.
  always_comb begin
    state_nx     = state;
    timer_nx     = timer;
    lat_nx       = lat;
    key_nx       = key;
    key_nx.valid = 1'b0;
    key_nx.rpt   = 1'b0;
    key_nx.multi = 1'b0;
    if (|btn_press) begin
      key_nx.valid = 1'b1;
      key_nx.code  = prio_code(btn_press);
      key_nx.multi = ($countones(btn_press) > 1);
      if (key_nx.multi)
        state_nx = ST_IDLE;
      else begin
        state_nx = ST_HOLD;
        lat_nx   = btn_press;
        timer_nx = TW'(REPEAT_DLY - 1);
      end
    end else if (state != ST_IDLE) begin
      if (~|(btn_level & lat))
        state_nx = ST_IDLE;
      else if (timer == '0) begin
        key_nx.valid = 1'b1;
        key_nx.rpt   = 1'b1;
        key_nx.code  = prio_code(lat);
        state_nx     = ST_REPEAT;
        timer_nx     = TW'(REPEAT_RATE - 1);
      end else
        timer_nx = timer - 1'b1;
    end
  end

  assign key_valid = key.valid;
  assign key_code  = key.code;
  assign key_rpt   = key.rpt;
  assign key_multi = key.multi;

endmodule

// File: tb/tb_btn_input_decoder.sv
// Directed bench for btn_input_decoder with short debounce/repeat timings.
module tb_btn_input_decoder;

  logic       CLOCK = 1'b0;
  logic       RESETN = 1'b1;
  logic [4:0] pins = 5'b0;
  logic [4:0] btn_level, btn_press;
  logic [2:0] key_code;
  logic       key_valid, key_rpt, key_multi;

  btn_input_decoder #(
    .N_BTN(5), .DEBOUNCE_CYC(4), .REPEAT_DLY(10), .REPEAT_RATE(3)
  ) dut (
    .CLOCK    (CLOCK),
    .RESETN   (RESETN),
    .btnC     (pins[0]),
    .btnU     (pins[1]),
    .btnD     (pins[2]),
    .btnR     (pins[3]),
    .btnL     (pins[4]),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_rpt  (key_rpt),
    .key_multi(key_multi)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  typedef struct {
    int         cyc;
    logic [2:0] code;
    logic       rpt;
    logic       multi;
  } evt_t;

  evt_t evq[$];
  evt_t expq[$];

  typedef struct {
    logic        restart;
    logic [4:0]  btn;
    logic [15:0] exp;   // {level, press, valid, code, rpt, multi}
  } vec_t;

  vec_t       vecs[36];
  logic [7:0] bpat;
  logic [4:0] lvl, prs;

  always @(posedge CLOCK) cyc <= cyc + 1;

  always @(negedge CLOCK)
    if (RESETN && key_valid)
      evq.push_back('{cyc: cyc - t0, code: key_code, rpt: key_rpt, multi: key_multi});

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic do_reset();
    pins   = 5'b0;
    RESETN = 1'b0;
    tick(2);
    RESETN = 1'b1;
  endtask

  task automatic start_seq();
    t0 = cyc;
    evq.delete();
    expq.delete();
  endtask

  task automatic exp_ev(input int c, input logic [2:0] k, input logic r, input logic m);
    expq.push_back('{cyc: c, code: k, rpt: r, multi: m});
  endtask

  task automatic cmp_evq(input string nm);
    chk({nm, "_count"}, evq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < evq.size(); i++) begin
      chk($sformatf("%s_ev%0d_cyc", nm, i), evq[i].cyc, expq[i].cyc);
      chk($sformatf("%s_ev%0d_key", nm, i),
          {evq[i].code, evq[i].rpt, evq[i].multi},
          {expq[i].code, expq[i].rpt, expq[i].multi});
    end
  endtask

  initial begin
    // Clean press of U: held cycles 0..7, level 6..13, pulse at 7, strobe at 8.
    for (int i = 0; i < 20; i++) begin
      vecs[i].restart = (i == 0);
      vecs[i].btn     = (i < 8) ? 5'b00010 : 5'b00000;
      lvl             = (i >= 6 && i < 14) ? 5'b00010 : 5'b00000;
      prs             = (i == 7) ? 5'b00010 : 5'b00000;
      vecs[i].exp     = {lvl, prs, (i == 8), ((i >= 8) ? 3'd2 : 3'd0), 1'b0, 1'b0};
    end
    // Bouncing C: 1,1,0,0,1,1,0,0 then quiet; nothing may come out.
    bpat = 8'b00110011;
    for (int j = 0; j < 16; j++) begin
      vecs[20+j].restart = (j == 0);
      vecs[20+j].btn     = {4'b0, (j < 8) ? bpat[j] : 1'b0};
      vecs[20+j].exp     = 16'h0;
    end

    #2 RESETN = 1'b0;
    #1 chk("reset_outputs", {btn_level, btn_press, key_valid, key_code, key_rpt, key_multi}, 32'h0);

    for (int i = 0; i < 36; i++) begin
      if (vecs[i].restart) do_reset();
      pins = vecs[i].btn;
      chk($sformatf("vec%0d", i),
          {btn_level, btn_press, key_valid, key_code, key_rpt, key_multi}, vecs[i].exp);
      tick(1);
    end

    // D and L together: one multi strobe, code D, no repeats.
    do_reset();
    start_seq();
    pins = 5'b10100;
    tick(30);
    chk("multi_level", btn_level, 5'b10100);
    pins = 5'b0;
    tick(10);
    exp_ev(8, 3'd2 + 3'd1, 1'b0, 1'b1);
    cmp_evq("multi");

    // R held 40 cycles: press at 8, repeats at 18 then every 3 until level falls at 46.
    do_reset();
    start_seq();
    pins = 5'b01000;
    tick(40);
    pins = 5'b0;
    tick(20);
    exp_ev(8, 3'd4, 1'b0, 1'b0);
    for (int c = 18; c <= 45; c += 3) exp_ev(c, 3'd4, 1'b1, 1'b0);
    cmp_evq("repeat");

    // R repeating, then C pressed: C strobe at 28, its repeats at 38 and 41.
    do_reset();
    start_seq();
    pins = 5'b01000;
    tick(20);
    pins = 5'b01001;
    tick(22);
    exp_ev(8, 3'd4, 1'b0, 1'b0);
    exp_ev(18, 3'd4, 1'b1, 1'b0);
    exp_ev(21, 3'd4, 1'b1, 1'b0);
    exp_ev(24, 3'd4, 1'b1, 1'b0);
    exp_ev(27, 3'd4, 1'b1, 1'b0);
    exp_ev(28, 3'd1, 1'b0, 1'b0);
    exp_ev(38, 3'd1, 1'b1, 1'b0);
    exp_ev(41, 3'd1, 1'b1, 1'b0);
    cmp_evq("repress");
    pins = 5'b0;
    tick(12);

    // Reset pulse while U is in HOLD, then a fresh press after release.
    do_reset();
    start_seq();
    pins = 5'b00010;
    tick(12);
    chk("pre_rst_code", key_code, 3'd2);
    RESETN = 1'b0;
    #1;
    chk("rst_async", {btn_level, btn_press, key_valid, key_code, key_rpt, key_multi}, 32'h0);
    @(posedge CLOCK);
    #1;
    RESETN = 1'b1;
    start_seq();
    tick(12);
    exp_ev(8, 3'd2, 1'b0, 1'b0);
    cmp_evq("rst_fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
